instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage feeding the decode stage, which holds the immediate generator. It owns the program counter and issues word fetches to instruction memory over a request/response interface. Returned words go into a small in-order buffer together with their PC. The buffer is presented to decode through a valid/ready handshake. A redirect from branch/JAL resolution reloads the PC, flushes the buffer and discards responses still in flight.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- DEPTH, 2: buffer entries; power of two, ≥2; also bounds outstanding requests.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  byte address of the word to fetch; always equals the PC register.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response word valid. Responses return in request order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  fetched instruction word.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; word-aligned.
- if_valid  out  1  buffer head valid toward decode.
- if_instr  out  32  head instruction.
- if_pc  out  32  head instruction's address.
- if_ready  in  1  decode consumes the head this cycle.

## Operation
- **State registers:**
  - pc: next request address.
  - resp_pc: address of the next kept response.
  - inflight: accepted requests not yet answered, 0..DEPTH.
  - discard: in-flight responses to drop, ≤ inflight.
  - FIFO: DEPTH × {instr, pc}, with count, rd_ptr and wr_ptr.
- **Pop:** pop = if_valid & if_ready.
- **Request issue:**
  - imem_req_valid = !rst & !redirect_valid & (inflight + count − pop < DEPTH).
  - This is combinational from if_ready and redirect_valid.
  - On acceptance (valid & ready): pc += 4 and inflight += 1.
- **Response arrival:**
  - inflight −= 1 on every response.
  - If discard > 0: decrement discard and drop the word.
  - Otherwise: push {imem_resp_data, resp_pc} into the FIFO and resp_pc += 4.
  - Credit accounting guarantees the FIFO is never full on a push. A push into a full FIFO is an assertion failure.
- **Output:**
  - if_valid = (count ≠ 0) & !redirect_valid.
  - if_instr and if_pc come from the FIFO head (first-word fall-through).
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Redirect** (has priority over every other update in the same cycle):
  - pc ← redirect_pc and resp_pc ← redirect_pc.
  - FIFO flushed: count ← 0, pointers ← 0.
  - No request is issued that cycle.
  - A response arriving in the same cycle is dropped and decrements inflight.
  - discard ← inflight − imem_resp_valid, so every still-pending response is marked stale.
  - A back-to-back redirect recomputes discard the same way.
- **Wrap-around:** pc and resp_pc wrap modulo 2^32. FIFO pointers wrap modulo DEPTH.
- **Address bits:** bits [1:0] of pc are never interpreted. Misalignment is handled downstream.

## Timing
- **During reset:** pc = resp_pc = RESET_PC; inflight = discard = count = 0; imem_req_valid = 0; if_valid = 0; imem_req_addr = RESET_PC; if_instr = if_pc = 0.
- **First request:** imem_req_valid rises in the first cycle after rst deasserts.
- **Fetch latency:** a request accepted in cycle N with a 1-cycle memory returns a response in N+1. The word appears with if_valid = 1 in N+2.
- **Throughput:** with a 1-cycle memory, if_ready held high and DEPTH = 2, the stage sustains one instruction per cycle after a 2-cycle fill.
- **Redirect latency:** redirect pulse in cycle R.
  - if_valid is low in R.
  - The first request to redirect_pc is issued in R+1.
  - The first kept word is visible at R+3 with a 1-cycle memory, later if discarded responses are still pending.
- **Reset mid-operation:** all state clears immediately. Responses for requests issued before reset must not reach the stage. Memory is reset by the same rst.

## Test plan
- **Reset and fill:** reset, RESET_PC = 0x100, 1-cycle memory, if_ready = 1 → requests 0x100, 0x104, 0x108…; if_valid first high 2 cycles after the first request; if_pc sequence 0x100, 0x104, 0x108 with the matching words, one per cycle.
- **Backpressure:** if_ready = 0 for 10 cycles → exactly DEPTH words buffered, imem_req_valid low, inflight 0; on release, words are delivered in order with none lost or duplicated.
- **Redirect with in-flight responses:** 3-cycle memory latency, redirect to 0x200 while 2 requests are outstanding → both late responses dropped; the next if_valid shows if_pc = 0x200; the old stream's words never appear.
- **Redirect collisions:** redirect in the same cycle as a response and a pop → response dropped, FIFO empty next cycle, if_valid low in the redirect cycle.
- **Memory stalls and wrap:** imem_req_ready toggled pseudo-randomly, with a redirect to 0xFFFF_FFFC → imem_req_addr holds while unaccepted; the PC sequence is 0xFFFF_FFFC then 0x0000_0000.
- **Async reset mid-burst:** rst asserted asynchronously mid-burst → if_valid and imem_req_valid drop without waiting for a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: imem request/response, redirect input
// and the valid/ready handshake toward decode.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests
// and buffers returned words with their PC, in order, toward decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   LIMIT = DEPTH[CW:0];
    localparam logic [CW-1:0] FULL  = DEPTH[CW-1:0];

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic          pop;
    logic          accept;
    logic          push;
    logic [CW:0]   credit;

    // Buffered plus in-flight words must never exceed the buffer size.
    assign pop    = bus.if_valid & bus.if_ready;
    assign credit = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};

    assign bus.imem_req_valid = !rst & !bus.redirect_valid & (credit < LIMIT);
    assign bus.imem_req_addr  = pc;
    assign accept = bus.imem_req_valid & bus.imem_req_ready;
    assign push   = bus.imem_resp_valid & (discard == '0);

    assign bus.if_valid = (count != '0) & !bus.redirect_valid;
    assign bus.if_instr = mem_instr[rd_ptr];
    assign bus.if_pc    = mem_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Every response still owed belongs to the old stream.
            pc       <= bus.redirect_pc;
            resp_pc  <= bus.redirect_pc;
            inflight <= inflight - CW'(bus.imem_resp_valid);
            discard  <= inflight - CW'(bus.imem_resp_valid);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (accept) begin
                pc <= pc + 32'd4;
            end
            inflight <= inflight + CW'(accept) - CW'(bus.imem_resp_valid);
            if (bus.imem_resp_valid && discard != '0) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                assert (count != FULL);
                mem_instr[wr_ptr] <= bus.imem_resp_data;
                mem_pc[wr_ptr]    <= resp_pc;
                wr_ptr            <= wr_ptr + AW'(1);
                resp_pc           <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: randomized memory/decode
// behaviour against a stream-level model of the fetched program.
module tb_instruction_fetch;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat = 1;
    int   rmode = 0;
    int   imode = 0;
    logic [31:0] exp_pc = RPC;
    mreq_t mq[$];
    exp_t  expq[$];

    instruction_fetch_if b ();

    instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Memory: accept at negedge, answer in order after lat cycles.
    always @(negedge clk) begin
        if (!rst && b.imem_req_valid && b.imem_req_ready) begin
            mq.push_back('{data: word_at(b.imem_req_addr), due: cyc + lat});
        end
    end

    always @(posedge rst) begin
        mq.delete();
        b.imem_resp_valid = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        b.imem_resp_valid = 1'b0;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            b.imem_resp_valid = 1'b1;
            b.imem_resp_data  = mq[0].data;
            void'(mq.pop_front());
        end
        b.imem_req_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        b.if_ready = (imode == 0) ? 1'b1 :
                     (imode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // Stimulus side of the scoreboard: each accepted fetch is the next
    // word of the program stream that started at the last reset/redirect.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            exp_pc = RPC;
        end else if (b.redirect_valid) begin
            chk("redir_if_valid", 32'(b.if_valid), 32'd0);
            chk("redir_req_valid", 32'(b.imem_req_valid), 32'd0);
            expq.delete();
            exp_pc = b.redirect_pc;
        end else if (b.imem_req_valid) begin
            chk("req_addr", b.imem_req_addr, exp_pc);
            if (b.imem_req_ready) begin
                expq.push_back('{pc: exp_pc, instr: word_at(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    // Monitor: every word handed to decode must be the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && b.if_valid && b.if_ready) begin
            if (expq.size() == 0) begin
                chk("pop_unexpected", b.if_pc, 32'hDEAD_DEAD);
            end else begin
                e = expq.pop_front();
                chk("out_pc", b.if_pc, e.pc);
                chk("out_instr", b.if_instr, e.instr);
            end
        end
    end

    task automatic wait_pop(input string nm, input logic [31:0] want);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b.if_valid && b.if_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) chk(nm, b.if_pc, want);
        else chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] a);
        @(posedge clk);
        #1;
        b.redirect_valid = 1'b1;
        b.redirect_pc    = a;
        @(posedge clk);
        #1;
        b.redirect_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        b.imem_req_ready  = 1'b1;
        b.imem_resp_valid = 1'b0;
        b.imem_resp_data  = '0;
        b.redirect_valid  = 1'b0;
        b.redirect_pc     = '0;
        b.if_ready        = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(b.if_valid), 32'd0);
        chk("rst_req_addr", b.imem_req_addr, RPC);
        chk("rst_if_instr", b.if_instr, 32'd0);
        chk("rst_if_pc", b.if_pc, 32'd0);

        // Fill: first request right after reset, word visible two cycles on.
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_req_valid", 32'(b.imem_req_valid), 32'd1);
        chk("fill_if_valid_0", 32'(b.if_valid), 32'd0);
        @(negedge clk);
        chk("fill_if_valid_1", 32'(b.if_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_if_valid", 32'(b.if_valid), 32'd1);
            chk("stream_pc", b.if_pc, RPC + 32'(4 * k));
        end

        // Backpressure: buffer fills to DEPTH and requests stop.
        imode = 1;
        repeat (10) @(negedge clk);
        chk("bp_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("bp_if_valid", 32'(b.if_valid), 32'd1);
        chk("bp_buffered", 32'(expq.size()), 32'(DEPTH));
        chk("bp_inflight", 32'(mq.size()), 32'd0);
        imode = 0;
        repeat (10) @(negedge clk);

        // Redirect with two responses outstanding on a slow memory.
        lat = 3;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mq.size() == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("two_outstanding", 32'(seen), 32'd1);
        redirect(32'h0000_0200);
        wait_pop("redir_first_pc", 32'h0000_0200);
        repeat (8) @(negedge clk);

        // Redirect colliding with a response and a pop on a 1-cycle memory.
        lat = 1;
        repeat (8) @(negedge clk);
        redirect(32'h0000_0300);
        @(negedge clk);
        chk("coll_if_valid_r1", 32'(b.if_valid), 32'd0);
        @(negedge clk);
        chk("coll_if_valid_r2", 32'(b.if_valid), 32'd0);
        @(negedge clk);
        chk("coll_if_valid_r3", 32'(b.if_valid), 32'd1);
        chk("coll_pc_r3", b.if_pc, 32'h0000_0300);

        // Memory stalls, random decode readiness, PC wrap.
        rmode = 1;
        imode = 2;
        repeat (5) @(negedge clk);
        redirect(32'hFFFF_FFFC);
        wait_pop("wrap_pc0", 32'hFFFF_FFFC);
        wait_pop("wrap_pc1", 32'h0000_0000);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                lat = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 60) == 0) begin
                redirect({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            end
        end

        // Asynchronous reset in the middle of a burst.
        rmode = 0;
        imode = 0;
        lat = 1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("async_if_valid", 32'(b.if_valid), 32'd0);
        chk("async_req_addr", b.imem_req_addr, RPC);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("restart_req_valid", 32'(b.imem_req_valid), 32'd1);
        wait_pop("restart_pc", RPC);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
